// File: rtl/expe.sv
`default_nettype none
// ============================================================================
// Module  : expe
// Brief   : Five-stage pipelined e^x for fix(16,8) log values, 64-bit result.
// Revision: 1.0
// ============================================================================
module expe #(
    parameter int EXP_OFFSET = 12,
    parameter int LOG2E_Q14  = 23637
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic        o_sat
);

    localparam logic signed [31:0] c_log2e = 32'(LOG2E_Q14);
    localparam logic        [18:0] c_bias  = 19'(EXP_OFFSET * 256);

    // 2^(i/16) in Q15
    function automatic logic [15:0] rom_a(input logic [3:0] idx);
        case (idx)
            4'd0:  return 16'd32768;
            4'd1:  return 16'd34219;
            4'd2:  return 16'd35734;
            4'd3:  return 16'd37316;
            4'd4:  return 16'd38968;
            4'd5:  return 16'd40693;
            4'd6:  return 16'd42495;
            4'd7:  return 16'd44376;
            4'd8:  return 16'd46341;
            4'd9:  return 16'd48393;
            4'd10: return 16'd50535;
            4'd11: return 16'd52773;
            4'd12: return 16'd55109;
            4'd13: return 16'd57549;
            4'd14: return 16'd60097;
            4'd15: return 16'd62757;
        endcase
    endfunction

    // 2^(j/256) in Q15
    function automatic logic [15:0] rom_b(input logic [3:0] idx);
        case (idx)
            4'd0:  return 16'd32768;
            4'd1:  return 16'd32857;
            4'd2:  return 16'd32946;
            4'd3:  return 16'd33035;
            4'd4:  return 16'd33125;
            4'd5:  return 16'd33215;
            4'd6:  return 16'd33305;
            4'd7:  return 16'd33395;
            4'd8:  return 16'd33486;
            4'd9:  return 16'd33576;
            4'd10: return 16'd33667;
            4'd11: return 16'd33759;
            4'd12: return 16'd33850;
            4'd13: return 16'd33942;
            4'd14: return 16'd34034;
            4'd15: return 16'd34126;
        endcase
    endfunction

    logic        r_s1_valid;
    logic [15:0] r_s1_data;
    logic        r_s2_valid;
    logic [18:0] r_s2_e;
    logic        r_s3_valid;
    logic [10:0] r_s3_k;
    logic [15:0] r_s3_a;
    logic [15:0] r_s3_b;
    logic        r_s4_valid;
    logic [10:0] r_s4_k;
    logic [15:0] r_s4_m;

    logic signed [31:0] w_prod;
    logic        [31:0] w_sum;
    logic        [17:0] w_t;
    logic        [18:0] w_e;
    logic        [31:0] w_ab;
    logic        [31:0] w_round;
    logic        [78:0] w_shift;
    logic               w_unused;

    // Rounded log2 value: bits [31:14] of the biased product are the arithmetic floor shift
    assign w_prod  = $signed({{16{r_s1_data[15]}}, r_s1_data}) * c_log2e;
    assign w_sum   = w_prod + 32'sd8192;
    assign w_t     = w_sum[31:14];
    assign w_e     = {w_t[17], w_t} + c_bias;

    assign w_ab    = 32'(r_s3_a) * 32'(r_s3_b);
    assign w_round = w_ab + 32'd16384;

    // m << k keeps every high bit; the floor divide by 2^15 drops the low 15
    assign w_shift = {63'd0, r_s4_m} << r_s4_k[5:0];

    assign w_unused = ^{w_sum[13:0], w_round[31], w_round[14:0], w_shift[14:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 16'd0;
            r_s2_valid <= 1'b0;
            r_s2_e     <= 19'd0;
            r_s3_valid <= 1'b0;
            r_s3_k     <= 11'd0;
            r_s3_a     <= 16'd0;
            r_s3_b     <= 16'd0;
            r_s4_valid <= 1'b0;
            r_s4_k     <= 11'd0;
            r_s4_m     <= 16'd0;
            o_valid    <= 1'b0;
            o_data     <= 64'd0;
            o_sat      <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_data  <= i_data;

            r_s2_valid <= r_s1_valid;
            r_s2_e     <= w_e;

            r_s3_valid <= r_s2_valid;
            r_s3_k     <= r_s2_e[18:8];
            r_s3_a     <= rom_a(r_s2_e[7:4]);
            r_s3_b     <= rom_b(r_s2_e[3:0]);

            r_s4_valid <= r_s3_valid;
            r_s4_k     <= r_s3_k;
            r_s4_m     <= w_round[30:15];

            o_valid    <= r_s4_valid;
            if (r_s4_valid) begin
                if (r_s4_k[10]) begin
                    o_data <= 64'd0;
                    o_sat  <= 1'b0;
                end else if (|r_s4_k[9:6]) begin
                    o_data <= {64{1'b1}};
                    o_sat  <= 1'b1;
                end else begin
                    o_data <= w_shift[78:15];
                    o_sat  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expe.sv
`default_nettype none
// Testbench for expe: random valid/data/reset stimulus against a real-math
// reference of e^x * 2^12, plus pinned literal results.
module tb_expe;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_valid;
    logic [63:0] o_data;
    logic        o_sat;

    expe dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sat   (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic        sat;
    } exp_t;

    exp_t q[$];
    int   tab_a[16];
    int   tab_b[16];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    logic done     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // {sat, data} for one input sample, from y = 2^(round(x*log2e) + 12)
    function automatic logic [64:0] ref_exp(input logic [15:0] x);
        longint p, t, e, k, f, m;
        logic [63:0] d;
        p = longint'($signed(x)) * 23637;
        t = (p + 8192) >>> 14;
        e = t + 12 * 256;
        k = e >>> 8;
        f = e & 255;
        m = (longint'(tab_a[f / 16]) * longint'(tab_b[f % 16]) + 16384) / 32768;
        if (k < 0) return {1'b0, 64'd0};
        if (k > 63) return {1'b1, {64{1'b1}}};
        if (k >= 15) d = 64'(m) << (k - 15);
        else d = 64'(m) >> (15 - k);
        return {1'b0, d};
    endfunction

    // Checker: owns the model, all counters and the end of the run
    initial begin
        logic [64:0] r;
        exp_t        ex;
        logic [63:0] last_d;
        logic        last_s;
        last_d = 64'd0;
        last_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tab_a[i] = $rtoi($pow(2.0, real'(i) / 16.0) * 32768.0 + 0.5);
            tab_b[i] = $rtoi($pow(2.0, real'(i) / 256.0) * 32768.0 + 0.5);
        end
        chk("pin_a0", 64'(tab_a[0]), 64'd32768);
        chk("pin_a8", 64'(tab_a[8]), 64'd46341);
        chk("pin_b1", 64'(tab_b[1]), 64'd32857);
        chk("pin_b15", 64'(tab_b[15]), 64'd34126);
        r = ref_exp(16'h0000); chk("pin_x0", {r[64], r[63:0]} , {1'b0, 64'd4096});
        r = ref_exp(16'h00B2); chk("pin_x00b2", r[63:0], 64'd8214);
        r = ref_exp(16'hFF00); chk("pin_xff00", r[63:0], 64'd1508);
        r = ref_exp(16'h7FFF); chk("pin_x7fff", 64'(r[64]), 64'd1);
        r = ref_exp(16'hF400); chk("pin_xf400", r[63:0], 64'd0);

        forever begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk("drain_empty", 64'(q.size()), 64'd0);
                $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
                $finish;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                ex = q.pop_front();
                chk("o_valid", 64'(o_valid), 64'd1);
                chk("o_data", o_data, ex.data);
                chk("o_sat", 64'(o_sat), 64'(ex.sat));
                last_d = ex.data;
                last_s = ex.sat;
            end else begin
                chk("o_valid_idle", 64'(o_valid), 64'd0);
                chk("o_data_hold", o_data, last_d);
                chk("o_sat_hold", 64'(o_sat), 64'(last_s));
            end
            // Inputs seen now are sampled on the next rising edge
            if (rst) begin
                q.delete();
                last_d = 64'd0;
                last_s = 1'b0;
            end else if (i_valid) begin
                r = ref_exp(i_data);
                q.push_back('{cyc + 5, r[63:0], r[64]});
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] d, input logic r);
        @(posedge clk);
        #1;
        i_valid = v;
        i_data  = d;
        rst     = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        logic [15:0] d;
        logic        v;
        logic        r;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        drive(1'b1, 16'h0000, 1'b0); idle(6);
        drive(1'b1, 16'h00B2, 1'b0); idle(6);
        drive(1'b1, 16'hFF00, 1'b0);
        drive(1'b1, 16'h7FFF, 1'b0);
        drive(1'b1, 16'hF400, 1'b0); idle(6);

        drive(1'b1, 16'h0000, 1'b0);
        drive(1'b1, 16'h00B2, 1'b0);
        drive(1'b0, 16'h1234, 1'b0);
        drive(1'b1, 16'hFF00, 1'b0); idle(6);

        drive(1'b1, 16'h0100, 1'b0);
        drive(1'b1, 16'h0200, 1'b0);
        drive(1'b1, 16'h0300, 1'b0);
        drive(1'b1, 16'h0400, 1'b1);
        idle(6);
        drive(1'b1, 16'h0000, 1'b0); idle(6);

        for (int n = 0; n < 3000; n++) begin
            v = ($urandom % 10) < 7;
            if ($urandom % 2 == 0) d = 16'($urandom);
            else d = 16'(int'($urandom_range(11500)) - 2200);
            r = ($urandom % 200) == 0;
            drive(v, d, r);
        end
        idle(10);
        done = 1'b1;
    end

endmodule
`default_nettype wire
